// File: rtl/store_narrow_buffer_pkg.sv
// Shared definitions for the store narrowing buffer.
// Holds the store-width encodings and the packed layout of one queued
// store entry: {addr[31:2], be[3:0], data[31:0]}, 66 bits in total.
package store_narrow_buffer_pkg;

  // Store width encodings carried on in_type (2'b11 is reserved and illegal)
  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  localparam int ENTRY_W = 66;

  // One queued store; the address is kept word-aligned, so only [31:2] is held
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/store_narrow_buffer_lane_pack.sv
// Combinational store lane packer.
// Maps a byte offset, store width and register value onto byte enables and
// lane-positioned data, and reports whether the combination is aligned.
// Ports:
//   offset - addr[1:0] of the store
//   stype  - store width (ST_SW / ST_SH / ST_SB; 2'b11 illegal)
//   data   - register data, value in the low bits
//   be     - byte enables for the 32-bit word
//   lanes  - data shifted into its byte lanes, unused lanes zero
//   legal  - 1 when the request is aligned for its width
module store_lane_pack
  import store_narrow_buffer_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  stype,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] lanes,
  output logic        legal
);

  // Width decode: byte enables, lane placement and alignment check
  always_comb begin
    be    = 4'b0000;
    lanes = 32'h0000_0000;
    legal = 1'b0;
    case (stype)
      ST_SW: begin
        legal = (offset == 2'b00);
        be    = 4'b1111;
        lanes = data;
      end
      ST_SH: begin
        legal = (offset[0] == 1'b0);
        if (offset[1]) begin
          be    = 4'b1100;
          lanes = {data[15:0], 16'h0000};
        end else begin
          be    = 4'b0011;
          lanes = {16'h0000, data[15:0]};
        end
      end
      ST_SB: begin
        legal = 1'b1;
        be    = 4'b0001 << offset;
        lanes = {24'h00_0000, data[7:0]} << {offset, 3'b000};
      end
      default: begin
        legal = 1'b0;
        be    = 4'b0000;
        lanes = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer between MEM-stage store issue and the DM write port.
// Narrows register data to sw/sh/sb, rejects misaligned stores with a
// one-cycle misalign_err pulse, and queues legal stores in a DEPTH-entry FIFO
// drained over a valid/ready handshake.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid/in_ready     - request handshake (in_ready = !full)
//   in_addr/in_data/in_type - byte address, register data, store width
//   out_valid/out_ready   - head handshake (out_valid = !empty)
//   out_addr/out_be/out_data - head entry, all zero while empty
//   misalign_err          - pulse the cycle after a rejected request
//   count                 - occupied entries
module store_narrow_buffer
  import store_narrow_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [3:0]       out_be,
  output logic [31:0]      out_data,
  output logic             misalign_err,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [PTR_W:0]     count_r;
  logic [PTR_W:0]     count_next_s;
  logic               misalign_r;

  logic [3:0]         pack_be_s;
  logic [31:0]        pack_data_s;
  logic               pack_legal_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  entry_t             new_entry_s;
  entry_t             head_s;

  store_lane_pack u_pack (
    .offset (in_addr[1:0]),
    .stype  (in_type),
    .data   (in_data),
    .be     (pack_be_s),
    .lanes  (pack_data_s),
    .legal  (pack_legal_s)
  );

  // Handshake decode; full blocks input even when a pop is happening
  always_comb begin
    in_ready    = (count_r != FULL_CNT);
    out_valid   = (count_r != {(PTR_W + 1){1'b0}});
    accept_s    = in_valid && in_ready;
    push_s      = accept_s && pack_legal_s;
    pop_s       = out_valid && out_ready;
    new_entry_s = '{addr: in_addr[31:2], be: pack_be_s, data: pack_data_s};
  end

  // Occupancy update: simultaneous push and pop leaves count unchanged
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      misalign_r <= 1'b0;
    end else begin
      // push and pop never target the same slot: that would need empty+pop or full+push
      if (push_s) begin
        mem_r[tail_r] <= new_entry_s;
        tail_r        <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        // vacated slots are zeroed so the head reads zero once the queue empties
        mem_r[head_r] <= '0;
        head_r        <= head_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      misalign_r <= accept_s && !pack_legal_s;
    end
  end

  // Head entry drives the write port straight from storage
  always_comb begin
    head_s       = mem_r[head_r];
    out_addr     = {head_s.addr, 2'b00};
    out_be       = head_s.be;
    out_data     = head_s.data;
    misalign_err = misalign_r;
    count        = count_r;
  end

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Self-checking bench for store_narrow_buffer: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a queue-based reference model.
module tb_store_narrow_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_data = 32'h0;
  logic [1:0]  in_type = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [3:0]  out_be;
  logic [31:0] out_data;
  logic        misalign_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_narrow_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_be(out_be), .out_data(out_data),
    .misalign_err(misalign_err), .count(count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // entry = {word address[31:0], be[3:0], data[31:0]}
  logic [67:0] q[$];
  logic        exp_mis;

  function automatic logic [68:0] model_pack(input logic [31:0] a, input logic [31:0] d,
                                             input logic [1:0] t);
    int unsigned o;
    logic        ok;
    logic [3:0]  be;
    logic [31:0] dd;
    o = a % 4;
    ok = 1'b0; be = 4'd0; dd = 32'd0;
    if (t == 2'd0) begin
      ok = (o == 0); be = 4'hF; dd = d;
    end else if (t == 2'd1) begin
      ok = (o % 2 == 0); be = 4'(3 << o); dd = (d & 32'h0000_FFFF) << (8 * o);
    end else if (t == 2'd2) begin
      ok = 1'b1; be = 4'(1 << o); dd = (d & 32'h0000_00FF) << (8 * o);
    end
    return {ok, a & 32'hFFFF_FFFC, be, dd};
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [68:0] p;
    logic        acc;
    if (reset) begin
      q.delete();
      exp_mis <= 1'b0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      p = model_pack(in_addr, in_data, in_type);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc && p[68]) q.push_back(p[67:0]);
      exp_mis <= acc && !p[68];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [67:0] h;
    if (!reset) begin
      h = (q.size() > 0) ? q[0] : 68'd0;
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check("count", 32'(count), 32'(q.size()));
      check("out_addr", out_addr, h[67:36]);
      check("out_be", 32'(out_be), 32'(h[35:32]));
      check("out_data", out_data, h[31:0]);
      check("misalign_err", 32'(misalign_err), 32'(exp_mis));
    end
  end

  // Apply inputs now (at a negedge) and advance to the next negedge
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] t, input logic r);
    in_valid = v; in_addr = a; in_data = d; in_type = t; out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // sb to the top byte lane
    step(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b10, 1'b0);
    check("sb_valid", 32'(out_valid), 32'd1);
    check("sb_addr", out_addr, 32'h0000_1000);
    check("sb_be", 32'(out_be), 32'h8);
    check("sb_data", out_data, 32'hAB00_0000);
    check("sb_mis", 32'(misalign_err), 32'd0);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    check("sb_drained", 32'(count), 32'd0);

    // sh upper half then sw, held, then drained in order
    step(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 2'b01, 1'b0);
    step(1'b1, 32'h0000_2004, 32'h1234_5678, 2'b00, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    check("sh_count", 32'(count), 32'd2);
    check("sh_be", 32'(out_be), 32'hC);
    check("sh_data", out_data, 32'hBEEF_0000);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    check("sw_be", 32'(out_be), 32'hF);
    check("sw_data", out_data, 32'h1234_5678);
    check("sw_addr", out_addr, 32'h0000_2004);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);

    // misaligned and reserved requests: one-cycle pulses, nothing queued
    step(1'b1, 32'h0000_3001, 32'h1, 2'b00, 1'b0);
    check("mis_sw", 32'(misalign_err), 32'd1);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    check("mis_sw_end", 32'(misalign_err), 32'd0);
    step(1'b1, 32'h0000_3003, 32'h2, 2'b01, 1'b0);
    check("mis_sh", 32'(misalign_err), 32'd1);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    check("mis_sh_end", 32'(misalign_err), 32'd0);
    step(1'b1, 32'h0000_3000, 32'h3, 2'b11, 1'b0);
    check("mis_rsv", 32'(misalign_err), 32'd1);
    check("mis_count", 32'(count), 32'd0);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    check("mis_rsv_end", 32'(misalign_err), 32'd0);
    check("mis_valid", 32'(out_valid), 32'd0);

    // fill, fifth ignored, then stream through with wrap
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_4000 + 32'(4 * i), 32'hA0 + 32'(i), 2'b00, 1'b0);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    step(1'b1, 32'h0000_5000, 32'hFF, 2'b00, 1'b0);
    check("fifth_ignored", 32'(count), 32'd4);
    check("fifth_head", out_data, 32'h0000_00A0);
    step(1'b1, 32'h0000_5000, 32'hB0, 2'b00, 1'b1);
    check("pop_on_full_count", 32'(count), 32'd3);
    check("ready_back", 32'(in_ready), 32'd1);
    for (int i = 1; i < 6; i++) step(1'b1, 32'h0000_5000 + 32'(4 * i), 32'hB0 + 32'(i), 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
    check("wrap_drained", 32'(count), 32'd0);

    // count 2, push+pop together, then async reset mid-cycle
    step(1'b1, 32'h0000_6000, 32'h11, 2'b10, 1'b0);
    step(1'b1, 32'h0000_6001, 32'h22, 2'b10, 1'b0);
    step(1'b1, 32'h0000_6002, 32'h33, 2'b10, 1'b1);
    check("pp_count", 32'(count), 32'd2);
    check("pp_head_data", out_data, 32'h0000_2200);
    check("pp_head_be", 32'(out_be), 32'h2);
    step(1'b1, 32'h0000_6001, 32'h44, 2'b00, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_mis", 32'(misalign_err), 32'd0);
    check("arst_data", out_data, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] t;
      t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, t, 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
